// File: rtl/next_pkg.sv
// Shared constants and types for the NeXT soundbox/keyboard serial link.
// The transmit encoder and the host->ASIC op decoder both import this package.
package next_pkg;

    localparam int OP_W      = 16;
    localparam int PAYLOAD_W = 24;
    localparam int FRAME_W   = OP_W + PAYLOAD_W;
    localparam int BIT_CNT_W = $clog2(PAYLOAD_W) + 1;

    localparam logic [OP_W-1:0] OP_ALL1     = 16'hffff;
    localparam logic [7:0]      OP_AUDIO_HI = 8'h07;
    localparam logic [7:0]      OP_KBD_HI   = 8'hc6;
    localparam logic [7:0]      OP_MOUSE_HI = 8'hc4;

    // Host->ASIC op high bytes recognised by the decoder side of the link.
    localparam logic [7:0] OP_DEC_C7 = 8'hc7;
    localparam logic [7:0] OP_DEC_C5 = 8'hc5;
    localparam logic [7:0] OP_DEC_0F = 8'h0f;
    localparam logic [7:0] OP_DEC_1F = 8'h1f;
    localparam logic [7:0] OP_DEC_FF = 8'hff;

    typedef enum logic [2:0] {
        IDLE,
        START,
        OP,
        DATA,
        STOP,
        GAP
    } tx_state_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_ALL1,
        SRC_AUDIO,
        SRC_KBD,
        SRC_MOUSE
    } tx_src_t;

    function automatic logic src_has_payload(input tx_src_t src);
        return (src == SRC_KBD) || (src == SRC_MOUSE);
    endfunction

    // Frames without payload leave the low 24 bits zero; they are never shifted out.
    function automatic logic [FRAME_W-1:0] build_frame(
        input tx_src_t              src,
        input logic [7:0]           audio_arg,
        input logic [PAYLOAD_W-1:0] kbd_data,
        input logic [PAYLOAD_W-1:0] mouse_data
    );
        logic [FRAME_W-1:0] frame;
        frame = '0;
        case (src)
            SRC_ALL1:  frame = {OP_ALL1, {PAYLOAD_W{1'b0}}};
            SRC_AUDIO: frame = {OP_AUDIO_HI, audio_arg, {PAYLOAD_W{1'b0}}};
            SRC_KBD:   frame = {OP_KBD_HI, 8'h00, kbd_data};
            SRC_MOUSE: frame = {OP_MOUSE_HI, 8'h00, mouse_data};
            default:   frame = '0;
        endcase
        return frame;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Serial bit timer: counts clk cycles within one bit and strobes bit_end on the
// last cycle of each bit while enabled. A clear restarts the bit from cycle 0.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt <= '0;
        end else if (clear) begin
            clk_cnt <= '0;
        end else if (enable) begin
            if (clk_cnt == CNT_LAST) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + CNT_W'(1);
            end
        end
    end

    assign bit_end = enable && !clear && (clk_cnt == CNT_LAST);

endmodule

// File: rtl/op_encoder_tx.sv
// ASIC->host op encoder: arbitrates all1/audio/keyboard/mouse requests and
// serializes each as start bit, 16-bit op, optional 24-bit payload, stop bit, idle gap.
module op_encoder_tx
    import next_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_BITS     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 all1_req,
    output logic                 all1_ack,
    input  logic                 audio_req,
    input  logic [7:0]           audio_req_arg,
    input  logic                 kbd_valid,
    input  logic [PAYLOAD_W-1:0] kbd_data,
    output logic                 kbd_ready,
    input  logic                 mouse_valid,
    input  logic [PAYLOAD_W-1:0] mouse_data,
    output logic                 mouse_ready,
    output logic                 tx_out,
    output logic                 busy
);

    localparam logic [BIT_CNT_W-1:0] CNT_OP_LAST   = BIT_CNT_W'(OP_W - 1);
    localparam logic [BIT_CNT_W-1:0] CNT_DATA_LAST = BIT_CNT_W'(PAYLOAD_W - 1);
    localparam logic [BIT_CNT_W-1:0] CNT_GAP_LAST  = BIT_CNT_W'(GAP_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_nxt;
    tx_src_t              winner;
    logic [FRAME_W-1:0]   shreg;
    logic                 has_payload;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] cnt_nxt;
    logic                 tx_reg;
    logic                 tx_nxt;
    logic                 load;
    logic                 shift_en;
    logic                 bit_end;
    logic                 audio_pend;
    logic [7:0]           audio_arg;

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state != IDLE),
        .clear   (load),
        .bit_end (bit_end)
    );

    always_comb begin
        winner = SRC_NONE;
        if (all1_req) begin
            winner = SRC_ALL1;
        end else if (audio_pend) begin
            winner = SRC_AUDIO;
        end else if (kbd_valid) begin
            winner = SRC_KBD;
        end else if (mouse_valid) begin
            winner = SRC_MOUSE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each field's last bit_end hands the line to the next field; bit_cnt counts down within a field.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        tx_nxt    = tx_reg;
        cnt_nxt   = bit_cnt;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (reset_n && (winner != SRC_NONE)) begin
                    load      = 1'b1;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = OP;
                    tx_nxt    = shreg[FRAME_W-1];
                    shift_en  = 1'b1;
                    cnt_nxt   = CNT_OP_LAST;
                end
            end
            OP: begin
                if (bit_end) begin
                    if (bit_cnt != '0) begin
                        tx_nxt   = shreg[FRAME_W-1];
                        shift_en = 1'b1;
                        cnt_nxt  = bit_cnt - BIT_CNT_W'(1);
                    end else if (has_payload) begin
                        state_nxt = DATA;
                        tx_nxt    = shreg[FRAME_W-1];
                        shift_en  = 1'b1;
                        cnt_nxt   = CNT_DATA_LAST;
                    end else begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt != '0) begin
                        tx_nxt   = shreg[FRAME_W-1];
                        shift_en = 1'b1;
                        cnt_nxt  = bit_cnt - BIT_CNT_W'(1);
                    end else begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = GAP;
                    tx_nxt    = 1'b1;
                    cnt_nxt   = CNT_GAP_LAST;
                end
            end
            GAP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    if (bit_cnt != '0) begin
                        cnt_nxt = bit_cnt - BIT_CNT_W'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_reg      <= 1'b1;
            bit_cnt     <= '0;
            shreg       <= '0;
            has_payload <= 1'b0;
        end else begin
            tx_reg  <= tx_nxt;
            bit_cnt <= cnt_nxt;
            if (load) begin
                shreg       <= build_frame(winner, audio_arg, kbd_data, mouse_data);
                has_payload <= src_has_payload(winner);
            end else if (shift_en) begin
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
            end
        end
    end

    // A new pulse wins over the clear so a request landing on the audio load cycle is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            audio_pend <= 1'b0;
            audio_arg  <= '0;
        end else if (audio_req) begin
            audio_pend <= 1'b1;
            audio_arg  <= audio_req_arg;
        end else if (load && (winner == SRC_AUDIO)) begin
            audio_pend <= 1'b0;
        end
    end

    assign all1_ack    = load && (winner == SRC_ALL1);
    assign kbd_ready   = load && (winner == SRC_KBD);
    assign mouse_ready = load && (winner == SRC_MOUSE);
    assign busy        = (state != IDLE) || load;
    assign tx_out      = tx_reg;

endmodule

// File: tb/tb_op_encoder_tx.sv
// Directed bench for op_encoder_tx: default-timing instance (a) and a fast
// instance (b, 2 clocks per bit, 1 gap bit) checked against hand-computed frames.
module tb_op_encoder_tx;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        all1_req_a, all1_ack_a, audio_req_a;
    logic [7:0]  audio_req_arg_a;
    logic        kbd_valid_a, kbd_ready_a, mouse_valid_a, mouse_ready_a;
    logic [23:0] kbd_data_a, mouse_data_a;
    logic        tx_out_a, busy_a;

    logic        all1_req_b, all1_ack_b, audio_req_b;
    logic [7:0]  audio_req_arg_b;
    logic        kbd_valid_b, kbd_ready_b, mouse_valid_b, mouse_ready_b;
    logic [23:0] kbd_data_b, mouse_data_b;
    logic        tx_out_b, busy_b;

    int checks   = 0;
    int failures = 0;

    int all1_cnt_a  = 0;
    int kbd_cnt_a   = 0;
    int mouse_cnt_a = 0;
    int kbd_cnt_b   = 0;
    int mouse_cnt_b = 0;

    always #5 clk = ~clk;

    op_encoder_tx #(.CLKS_PER_BIT(4), .GAP_BITS(2)) dut_a (
        .clk           (clk),
        .reset_n       (reset_n),
        .all1_req      (all1_req_a),
        .all1_ack      (all1_ack_a),
        .audio_req     (audio_req_a),
        .audio_req_arg (audio_req_arg_a),
        .kbd_valid     (kbd_valid_a),
        .kbd_data      (kbd_data_a),
        .kbd_ready     (kbd_ready_a),
        .mouse_valid   (mouse_valid_a),
        .mouse_data    (mouse_data_a),
        .mouse_ready   (mouse_ready_a),
        .tx_out        (tx_out_a),
        .busy          (busy_a)
    );

    op_encoder_tx #(.CLKS_PER_BIT(2), .GAP_BITS(1)) dut_b (
        .clk           (clk),
        .reset_n       (reset_n),
        .all1_req      (all1_req_b),
        .all1_ack      (all1_ack_b),
        .audio_req     (audio_req_b),
        .audio_req_arg (audio_req_arg_b),
        .kbd_valid     (kbd_valid_b),
        .kbd_data      (kbd_data_b),
        .kbd_ready     (kbd_ready_b),
        .mouse_valid   (mouse_valid_b),
        .mouse_data    (mouse_data_b),
        .mouse_ready   (mouse_ready_b),
        .tx_out        (tx_out_b),
        .busy          (busy_b)
    );

    // Inputs only change at posedge+1, so negedge sampling sees settled strobes.
    always @(negedge clk) begin
        if (all1_ack_a)    all1_cnt_a  <= all1_cnt_a + 1;
        if (kbd_ready_a)   kbd_cnt_a   <= kbd_cnt_a + 1;
        if (mouse_ready_a) mouse_cnt_a <= mouse_cnt_a + 1;
        if (kbd_ready_b)   kbd_cnt_b   <= kbd_cnt_b + 1;
        if (mouse_ready_b) mouse_cnt_b <= mouse_cnt_b + 1;
    end

    function automatic logic line_of(input bit sel);
        return sel ? tx_out_b : tx_out_a;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    function automatic logic ready_of(input int which);
        case (which)
            0:       return kbd_ready_a;
            1:       return mouse_ready_a;
            default: return kbd_ready_b;
        endcase
    endfunction

    task automatic wait_ready(input int which, input string name, output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ready_of(which)) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL %s: ready not seen within 3000 cycles (got 0, need 1)", name);
        end
    endtask

    // Receives one frame bit by bit at negedges, then checks the idle gap after it.
    task automatic recv_frame(input bit sel, input int cpb, input int gap, input bit has_pl,
                              input logic [15:0] exp_op, input logic [23:0] exp_pl,
                              input string name, output int waited);
        logic [41:0] word;
        logic [15:0] op;
        logic [23:0] pl;
        logic        cur, v;
        bit          got, unstable, gap_bad;
        int          nbits;
        nbits    = has_pl ? 42 : 18;
        waited   = 0;
        got      = 1'b0;
        unstable = 1'b0;
        gap_bad  = 1'b0;
        word     = '0;
        cur      = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            waited++;
            if (line_of(sel) == 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL %s start: no start bit within 3000 cycles (got 0, need 1)", name);
            return;
        end
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                v = line_of(sel);
                if (c == 0) begin
                    word = {word[40:0], v};
                    cur  = v;
                end else if (v !== cur) begin
                    unstable = 1'b1;
                end
            end
        end
        op = has_pl ? word[40:25] : word[16:1];
        pl = word[24:1];
        checks++;
        if (op !== exp_op) begin
            failures++;
            $display("[TB] FAIL %s op: got %h, need %h", name, op, exp_op);
        end
        if (has_pl) begin
            checks++;
            if (pl !== exp_pl) begin
                failures++;
                $display("[TB] FAIL %s payload: got %h, need %h", name, pl, exp_pl);
            end
        end
        checks++;
        if (word[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s stop: got %b, need 1", name, word[0]);
        end
        checks++;
        if (unstable) begin
            failures++;
            $display("[TB] FAIL %s bit_width: line changed inside a bit (got 1, need 0)", name);
        end
        for (int g = 0; g < gap * cpb; g++) begin
            @(negedge clk);
            if (line_of(sel) !== 1'b1 || busy_of(sel) !== 1'b1) gap_bad = 1'b1;
        end
        checks++;
        if (gap_bad) begin
            failures++;
            $display("[TB] FAIL %s gap: line/busy not high through gap (got 1, need 0)", name);
        end
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        all1_req_a      = 0; audio_req_a = 0; audio_req_arg_a = '0;
        kbd_valid_a     = 1; kbd_data_a  = 24'h123456;
        mouse_valid_a   = 0; mouse_data_a = '0;
        all1_req_b      = 0; audio_req_b = 0; audio_req_arg_b = '0;
        kbd_valid_b     = 0; kbd_data_b  = '0;
        mouse_valid_b   = 0; mouse_data_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_out_a !== 1'b1 || tx_out_b !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_tx: got %b%b, need 11", tx_out_a, tx_out_b);
        end
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b%b, need 00", busy_a, busy_b);
        end
        checks++;
        if ({all1_ack_a, kbd_ready_a, mouse_ready_a} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_strobes: got %b, need 000",
                     {all1_ack_a, kbd_ready_a, mouse_ready_a});
        end
        @(posedge clk); #1;
        kbd_valid_a = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_kbd_frame();
        int w;
        int k0;
        k0 = kbd_cnt_a;
        kbd_valid_a = 1; kbd_data_a = 24'hA5C301;
        @(negedge clk);
        checks++;
        if (kbd_ready_a !== 1'b1 || busy_a !== 1'b1) begin
            failures++;
            $display("[TB] FAIL kbd_load: ready/busy got %b%b, need 11", kbd_ready_a, busy_a);
        end
        @(posedge clk); #1;
        kbd_valid_a = 0;
        recv_frame(0, 4, 2, 1, 16'hc600, 24'hA5C301, "kbd", w);
        checks++;
        if (w != 1) begin
            failures++;
            $display("[TB] FAIL kbd_latency: got %0d, need 1", w);
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL kbd_busy_after_gap: got %b, need 0", busy_a);
        end
        checks++;
        if (kbd_cnt_a - k0 != 1) begin
            failures++;
            $display("[TB] FAIL kbd_ready_pulses: got %0d, need 1", kbd_cnt_a - k0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_audio();
        int w1, w2, lows;
        audio_req_a = 1; audio_req_arg_a = 8'h3c;
        @(posedge clk); #1;
        audio_req_a = 0; audio_req_arg_a = 8'h00;
        fork
            recv_frame(0, 4, 2, 0, 16'h073c, 24'h0, "audio1", w1);
            begin
                repeat (30) @(posedge clk);
                #1;
                audio_req_a = 1; audio_req_arg_a = 8'h11;
                @(posedge clk); #1;
                audio_req_a = 0; audio_req_arg_a = 8'h00;
            end
        join
        recv_frame(0, 4, 2, 0, 16'h0711, 24'h0, "audio2", w2);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_out_a == 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("[TB] FAIL audio_extra_frame: low samples got %0d, need 0", lows);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_priority();
        int  w, a0, k0, m0;
        bit  gk, gm;
        a0 = all1_cnt_a; k0 = kbd_cnt_a; m0 = mouse_cnt_a;
        all1_req_a    = 1;
        audio_req_a   = 1; audio_req_arg_a = 8'h5a;
        kbd_valid_a   = 1; kbd_data_a      = 24'h0F1E2D;
        mouse_valid_a = 1; mouse_data_a    = 24'h800001;
        @(negedge clk);
        checks++;
        if ({all1_ack_a, kbd_ready_a, mouse_ready_a} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL prio_first_load: got %b, need 100",
                     {all1_ack_a, kbd_ready_a, mouse_ready_a});
        end
        @(posedge clk); #1;
        all1_req_a = 0; audio_req_a = 0; audio_req_arg_a = 8'h00;
        fork
            begin
                recv_frame(0, 4, 2, 0, 16'hffff, 24'h0, "prio_all1", w);
                recv_frame(0, 4, 2, 0, 16'h075a, 24'h0, "prio_audio", w);
                recv_frame(0, 4, 2, 1, 16'hc600, 24'h0F1E2D, "prio_kbd", w);
                recv_frame(0, 4, 2, 1, 16'hc400, 24'h800001, "prio_mouse", w);
            end
            begin
                wait_ready(0, "prio_kbd_ready", gk);
                @(posedge clk); #1;
                kbd_valid_a = 0;
            end
            begin
                wait_ready(1, "prio_mouse_ready", gm);
                @(posedge clk); #1;
                mouse_valid_a = 0;
            end
        join
        checks++;
        if (all1_cnt_a - a0 != 1 || kbd_cnt_a - k0 != 1 || mouse_cnt_a - m0 != 1) begin
            failures++;
            $display("[TB] FAIL prio_pulses: ack/kbd/mouse got %0d/%0d/%0d, need 1/1/1",
                     all1_cnt_a - a0, kbd_cnt_a - k0, mouse_cnt_a - m0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        int w, m0;
        bit got, gm;
        m0 = mouse_cnt_a;
        mouse_valid_a = 1; mouse_data_a = 24'h3C5A96;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_out_a == 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL rst_mid_start: no start bit (got 0, need 1)");
        end
        repeat (20 * 4) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx_out_a !== 1'b1 || busy_a !== 1'b0 || mouse_ready_a !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_async: tx/busy/ready got %b%b%b, need 100",
                     tx_out_a, busy_a, mouse_ready_a);
        end
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        fork
            recv_frame(0, 4, 2, 1, 16'hc400, 24'h3C5A96, "rst_mid_fresh", w);
            begin
                wait_ready(1, "rst_mid_ready", gm);
                @(posedge clk); #1;
                mouse_valid_a = 0;
            end
        join
        checks++;
        if (mouse_cnt_a - m0 != 2) begin
            failures++;
            $display("[TB] FAIL rst_mid_pulses: got %0d, need 2", mouse_cnt_a - m0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int w1, w2, lows, k0, m0;
        bit g1, g2;
        k0 = kbd_cnt_b; m0 = mouse_cnt_b;
        kbd_valid_b = 1; kbd_data_b = 24'h010203;
        fork
            begin
                recv_frame(1, 2, 1, 1, 16'hc600, 24'h010203, "b2b_first", w1);
                recv_frame(1, 2, 1, 1, 16'hc600, 24'hFEDCBA, "b2b_second", w2);
            end
            begin
                wait_ready(2, "b2b_ready1", g1);
                @(posedge clk); #1;
                kbd_data_b    = 24'hFEDCBA;
                mouse_valid_b = 1; mouse_data_b = 24'h777777;
                repeat (10) @(posedge clk);
                #1;
                mouse_valid_b = 0;
                wait_ready(2, "b2b_ready2", g2);
                @(posedge clk); #1;
                kbd_valid_b = 0;
            end
        join
        checks++;
        if (w2 != 2) begin
            failures++;
            $display("[TB] FAIL b2b_spacing: cycles to next start got %0d, need 2", w2);
        end
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_out_b == 1'b0) lows++;
        end
        checks++;
        if (lows != 0 || mouse_cnt_b - m0 != 0 || kbd_cnt_b - k0 != 2) begin
            failures++;
            $display("[TB] FAIL b2b_mouse_dropped: lows/mouse/kbd got %0d/%0d/%0d, need 0/0/2",
                     lows, mouse_cnt_b - m0, kbd_cnt_b - k0);
        end
    endtask

    initial begin
        test_reset();
        test_kbd_frame();
        test_audio();
        test_priority();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
